pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 154 +++++++++++++++
 tb/tb_pc_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection and fetch control for a simple in-order core.
// It walks a four-state FSM (BOOT, RUN, WAIT, TRAP). It decides the value the
// external PC register loads each cycle and tracks the exception PC. It also
// remembers any redirect that shows up while waiting on instruction memory.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        exc,
    input  logic        eret,
    output logic [31:0] epc,
    output logic        flush,
    output logic [1:0]  state
);

    localparam logic [1:0] BOOT = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] WAIT = 2'b10;
    localparam logic [1:0] TRAP = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic [31:0] pcPlus4;
    logic        evtValid;
    logic [31:0] evtTarget;
    logic [31:0] evtAligned;
    logic        takeValid;
    logic [31:0] takeTarget;

    assign epc   = epc_q;
    assign state = state_q;

    // Resolve this cycle's redirect request (eret > branch > jump) to a word-aligned target
    always_comb begin
        pcPlus4    = pc + 32'd4;
        evtValid   = eret | br_taken | jmp;
        if (eret) begin
            evtTarget = epc_q;
        end else if (br_taken) begin
            evtTarget = br_target;
        end else begin
            evtTarget = jmp_target;
        end
        evtAligned = evtTarget & ~32'h0000_0003;
        // A redirect arriving in the same cycle as the fetch completes is the newest one
        takeValid  = evtValid | pend_valid_q;
        takeTarget = evtValid ? evtAligned : pend_target_q;
    end

    // Next-state, next-PC and fetch/flush control
    always_comb begin
        state_d       = state_q;
        epc_d         = epc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pc_next       = pc;
        imem_req      = 1'b0;
        flush         = 1'b0;

        case (state_q)
            BOOT: begin
                pc_next = RESET_VEC;
                state_d = RUN;
            end

            RUN: begin
                imem_req = 1'b1;
                if (exc) begin
                    epc_d   = pc;
                    pc_next = EXC_VEC;
                    flush   = 1'b1;
                    state_d = TRAP;
                end else if (evtValid) begin
                    pc_next = evtAligned;
                    flush   = 1'b1;
                end else if (stall) begin
                    pc_next = pc;
                end else if (imem_ready) begin
                    pc_next = pcPlus4;
                end else begin
                    pc_next = pc;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                imem_req = 1'b1;
                if (exc) begin
                    epc_d         = pc;
                    pc_next       = EXC_VEC;
                    flush         = 1'b1;
                    pend_valid_d  = 1'b0;
                    pend_target_d = 32'h0;
                    state_d       = TRAP;
                end else if (imem_ready) begin
                    pc_next       = takeValid ? takeTarget : pcPlus4;
                    flush         = takeValid;
                    pend_valid_d  = 1'b0;
                    pend_target_d = 32'h0;
                    state_d       = RUN;
                end else if (evtValid) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = evtAligned;
                end
            end

            TRAP: begin
                pc_next = pc;
                state_d = RUN;
            end

            default: begin
                state_d = BOOT;
            end
        endcase

        // While reset is held the PC register is steered to the reset vector
        if (rst) begin
            pc_next  = RESET_VEC;
            imem_req = 1'b0;
            flush    = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            epc_q         <= 32'h0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            epc_q         <= epc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors for pc_sequencer with hand-computed expectations.
// The bench plays the role of the PC register by driving pc to the value it
// expects the previous cycle's pc_next to have been.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        imem_req;
    logic        imem_ready;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic        flush;
    logic [1:0]  state;

    int checkCount = 0;
    int passCount  = 0;

    localparam logic [1:0] BOOT = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] WAIT = 2'b10;
    localparam logic [1:0] TRAP = 2'b11;

    pc_sequencer #(
        .RESET_VEC(32'h0000_0000),
        .EXC_VEC  (32'h0000_0180)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .pc_next   (pc_next),
        .imem_req  (imem_req),
        .imem_ready(imem_ready),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jmp       (jmp),
        .jmp_target(jmp_target),
        .exc       (exc),
        .eret      (eret),
        .epc       (epc),
        .flush     (flush),
        .state     (state)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic stl, input logic br, input logic [31:0] brT,
                                 input logic jp, input logic [31:0] jpT,
                                 input logic ex, input logic er, input logic rdy);
        stall      = stl;
        br_taken   = br;
        br_target  = brT;
        jmp        = jp;
        jmp_target = jpT;
        exc        = ex;
        eret       = er;
        imem_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkComb(input string tag, input logic [31:0] expPc, input logic expReq,
                             input logic expFlush, input logic [1:0] expState);
        checkOutput({tag, ".pc_next"}, pc_next, expPc);
        checkOutput({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, expReq});
        checkOutput({tag, ".flush"}, {31'b0, flush}, {31'b0, expFlush});
        checkOutput({tag, ".state"}, {30'b0, state}, {30'b0, expState});
    endtask

    initial begin
        rst = 1'b1;
        pc  = 32'h0;
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);

        // Reset held across an edge
        tick();
        checkComb("rst", 32'h0, 0, 0, BOOT);
        checkOutput("rst.epc", epc, 32'h0);

        // BOOT cycle, then sequential fetch
        rst = 1'b0;
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        checkComb("boot", 32'h0, 0, 0, BOOT);
        tick();
        pc = 32'h0;
        #1;
        checkComb("seq0", 32'h4, 1, 0, RUN);
        tick();
        pc = 32'h4;
        #1;
        checkComb("seq1", 32'h8, 1, 0, RUN);
        tick();
        pc = 32'h8;
        #1;
        checkComb("seq2", 32'hC, 1, 0, RUN);

        // Fetch miss at 0x40, branch arrives during WAIT, applied on completion
        tick();
        pc = 32'h40;
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        checkComb("miss.run", 32'h40, 1, 0, RUN);
        tick();
        checkComb("miss.wait1", 32'h40, 1, 0, WAIT);
        tick();
        applyStimulus(0, 1, 32'h200, 0, 32'h0, 0, 0, 0);
        checkComb("miss.wait2", 32'h40, 1, 0, WAIT);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        checkComb("miss.done", 32'h200, 1, 1, WAIT);
        tick();
        pc = 32'h200;
        #1;
        checkComb("miss.run2", 32'h204, 1, 0, RUN);

        // Exception at 0x100, one TRAP cycle ignoring events, then eret
        tick();
        pc = 32'h100;
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 1);
        checkComb("exc", 32'h180, 1, 1, RUN);
        tick();
        pc = 32'h180;
        applyStimulus(1, 1, 32'h700, 1, 32'h704, 1, 1, 1);
        checkComb("trap", 32'h180, 0, 0, TRAP);
        checkOutput("trap.epc", epc, 32'h100);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 1, 1);
        checkComb("eret", 32'h100, 1, 1, RUN);
        checkOutput("eret.epc", epc, 32'h100);

        // Wrap at the top of the address space
        tick();
        pc = 32'hFFFF_FFFC;
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        checkComb("wrap", 32'h0000_0000, 1, 0, RUN);

        // Jump overrides stall and is word-aligned; stall alone holds
        tick();
        pc = 32'h10;
        applyStimulus(1, 0, 32'h0, 1, 32'h0000_0403, 0, 0, 0);
        checkComb("jmpstall", 32'h400, 1, 1, RUN);
        tick();
        pc = 32'h400;
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        checkComb("stall", 32'h400, 1, 0, RUN);

        // Branch beats jump when both are taken
        tick();
        applyStimulus(0, 1, 32'h801, 1, 32'h900, 0, 0, 1);
        checkComb("brjmp", 32'h800, 1, 1, RUN);

        // exc and eret together: exc wins and epc takes the new pc
        tick();
        pc = 32'h300;
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 1, 1);
        checkComb("excEret", 32'h180, 1, 1, RUN);
        tick();
        pc = 32'h180;
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        checkOutput("excEret.epc", epc, 32'h300);
        checkOutput("excEret.state", {30'b0, state}, {30'b0, TRAP});
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 1, 1);
        checkComb("excEret.ret", 32'h300, 1, 1, RUN);

        // Reset in the middle of WAIT with a pending jump
        tick();
        pc = 32'h50;
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        checkComb("rstWait.run", 32'h50, 1, 0, RUN);
        tick();
        applyStimulus(0, 0, 32'h0, 1, 32'h600, 0, 0, 0);
        checkComb("rstWait.wait", 32'h50, 1, 0, WAIT);
        tick();
        rst = 1'b1;
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        checkComb("rstWait.rst", 32'h0, 0, 0, WAIT);
        tick();
        rst = 1'b0;
        pc  = 32'h0;
        #1;
        checkComb("rstWait.boot", 32'h0, 0, 0, BOOT);
        tick();
        checkComb("rstWait.fetch", 32'h4, 1, 0, RUN);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
